// File: rtl/ste_avg_pkg.sv
// rtl/ste_avg_pkg.sv - shared types, defaults and helpers for the multi-channel IIR averager
package ste_avg_pkg;

  typedef logic [2:0] alpha_sel_t;

  localparam int K_MAX_DEFAULT = 7;

  // Channel index width; a single-channel build still carries a 1-bit index.
  function automatic int ch_w(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/ste_avg_iir_step.sv
// rtl/ste_avg_iir_step.sv - one-sample IIR update datapath; STE_AVG_IIR_MC_ROUND_EN selects rounded output
module ste_avg_iir_step
  import ste_avg_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int FRAC_W = 8,
  localparam int SW     = DATA_W + FRAC_W
) (
  input  logic [SW-1:0]     s,
  input  logic [SW-1:0]     x,
  input  alpha_sel_t        k,
  input  logic              en,
  input  logic              init,
  output logic [SW-1:0]     s_new,
  output logic [DATA_W-1:0] dout,
  output logic              changed
);

  localparam int OW = DATA_W + 1;

`ifdef STE_AVG_IIR_MC_ROUND_EN
  localparam int RW = SW + 1;
  localparam logic [RW-1:0] HALF = RW'(1) << (FRAC_W - 1);

  function automatic logic [DATA_W-1:0] to_out(input logic [SW-1:0] v);
    logic [OW-1:0] q;
    q = OW'((RW'(v) + HALF) >> FRAC_W);
    return q[DATA_W] ? '1 : q[DATA_W-1:0];
  endfunction
`else
  function automatic logic [DATA_W-1:0] to_out(input logic [SW-1:0] v);
    return DATA_W'(v >> FRAC_W);
  endfunction
`endif

  logic signed [SW:0]  diff;
  logic [DATA_W-1:0]   dout_old;

  // The shifted correction always lands back inside [0, 2^SW-1], so a modular add is exact.
  always_comb begin
    diff = $signed({1'b0, x}) - $signed({1'b0, s});
    if (!init || !en || (k == '0)) begin
      s_new = x;
    end else begin
      s_new = s + SW'(diff >>> k);
    end
    dout     = to_out(s_new);
    dout_old = to_out(s);
    changed  = !init || (dout != dout_old);
  end

endmodule

// File: rtl/ste_avg_iir_mc.sv
// rtl/ste_avg_iir_mc.sv - time-multiplexed per-channel IIR averager top; output rounding via STE_AVG_IIR_MC_ROUND_EN
module ste_avg_iir_mc
  import ste_avg_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NUM_CH = 4,
  parameter  int FRAC_W = 8,
  parameter  int K_MAX  = K_MAX_DEFAULT,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din_i,
  input  logic [CH_W-1:0]   din_ch_i,
  input  logic              din_vld_i,
  input  logic              avg_clr_i,
  input  logic              avg_en_i,
  input  logic [2:0]        alpha_sel_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [CH_W-1:0]   dout_ch_o,
  output logic              dout_vld_o,
  output logic              dout_update_o
);

  localparam int SW = DATA_W + FRAC_W;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic [SW-1:0]   x;
    alpha_sel_t      k;
    logic            en;
  } in_t;

  typedef struct packed {
    logic            vld;
    logic [CH_W-1:0] ch;
    logic [SW-1:0]   x;
    alpha_sel_t      k;
    logic            en;
    logic            init;
    logic [SW-1:0]   s;
  } s1_t;

  logic [SW-1:0]     st     [NUM_CH];
  logic              init_q [NUM_CH];
  in_t               p1;
  s1_t               p2;

  alpha_sel_t        k_in;
  logic              accept;
  logic              fwd;
  logic [SW-1:0]     rd_s;
  logic              rd_init;
  logic [SW-1:0]     s_new;
  logic [DATA_W-1:0] dout_nx;
  logic              changed;

  always_comb begin
    k_in    = (alpha_sel_i > alpha_sel_t'(K_MAX)) ? alpha_sel_t'(K_MAX) : alpha_sel_i;
    accept  = din_vld_i && (32'(din_ch_i) < NUM_CH);
    // A back-to-back sample on the same channel must see the result still in flight.
    fwd     = p2.vld && (p2.ch == p1.ch);
    rd_s    = fwd ? s_new : st[p1.ch];
    rd_init = fwd || init_q[p1.ch];
  end

  ste_avg_iir_step #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_step (
    .s       (p2.s),
    .x       (p2.x),
    .k       (p2.k),
    .en      (p2.en),
    .init    (p2.init),
    .s_new   (s_new),
    .dout    (dout_nx),
    .changed (changed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1.vld  <= accept;
      p1.ch   <= din_ch_i;
      p1.x    <= {din_i, {FRAC_W{1'b0}}};
      p1.k    <= k_in;
      p1.en   <= avg_en_i;
      p2.vld  <= p1.vld && !avg_clr_i;
      p2.ch   <= p1.ch;
      p2.x    <= p1.x;
      p2.k    <= p1.k;
      p2.en   <= p1.en;
      p2.init <= rd_init;
      p2.s    <= rd_s;
    end
  end

  // A clear wins over the write-back of the sample finishing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st[i]     <= '0;
        init_q[i] <= 1'b0;
      end
    end else if (avg_clr_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        init_q[i] <= 1'b0;
      end
    end else if (p2.vld) begin
      st[p2.ch]     <= s_new;
      init_q[p2.ch] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_o        <= '0;
      dout_ch_o     <= '0;
      dout_vld_o    <= 1'b0;
      dout_update_o <= 1'b0;
    end else begin
      dout_vld_o    <= p2.vld;
      dout_update_o <= p2.vld && changed;
      if (p2.vld) begin
        dout_o    <= dout_nx;
        dout_ch_o <= p2.ch;
      end
    end
  end

endmodule

// File: tb/tb_ste_avg_iir_mc.sv
// tb/tb_ste_avg_iir_mc.sv - self-checking bench for ste_avg_iir_mc with a behavioural channel model
module tb_ste_avg_iir_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] din;
  logic [1:0]  din_ch;
  logic        din_vld, avg_clr, avg_en;
  logic [2:0]  alpha_sel;
  logic [15:0] dout;
  logic [1:0]  dout_ch;
  logic        dout_vld, dout_update;

  logic [2:0]  oor_ch;
  logic [15:0] oor_dout;
  logic [2:0]  oor_dout_ch;
  logic        oor_vld, oor_upd;

  ste_avg_iir_mc #(.DATA_W(16), .NUM_CH(4), .FRAC_W(8), .K_MAX(7)) dut (
    .clk(clk), .rst(rst), .din_i(din), .din_ch_i(din_ch), .din_vld_i(din_vld),
    .avg_clr_i(avg_clr), .avg_en_i(avg_en), .alpha_sel_i(alpha_sel),
    .dout_o(dout), .dout_ch_o(dout_ch), .dout_vld_o(dout_vld), .dout_update_o(dout_update)
  );

  ste_avg_iir_mc #(.DATA_W(16), .NUM_CH(5), .FRAC_W(8), .K_MAX(7)) u_oor (
    .clk(clk), .rst(rst), .din_i(din), .din_ch_i(oor_ch), .din_vld_i(din_vld),
    .avg_clr_i(avg_clr), .avg_en_i(avg_en), .alpha_sel_i(alpha_sel),
    .dout_o(oor_dout), .dout_ch_o(oor_dout_ch), .dout_vld_o(oor_vld), .dout_update_o(oor_upd)
  );

`ifdef STE_AVG_IIR_MC_ROUND_EN
  localparam int WARM3 = 1438;
`else
  localparam int WARM3 = 1437;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  typedef struct {int cyc; int d; int ch; bit upd;} ev_t;
  ev_t log_q[$];
  ev_t oor_q[$];

  longint m_s [4];
  bit     m_init [4];
  bit     p1_v, p2_v, p1_en, p2_en;
  int     p1_d, p2_d, p1_ch, p2_ch, p1_k, p2_k;
  bit     e_vld, e_upd;
  int     e_dout, e_ch;

  task automatic chk(input string nm, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, got, want);
    end
  endtask

  function automatic int out_of(input longint s);
`ifdef STE_AVG_IIR_MC_ROUND_EN
    longint r;
    r = (s + 128) / 256;
    return (r > 65535) ? 65535 : int'(r);
`else
    return int'(s / 256);
`endif
  endfunction

  // alpha = 2^-k applied as floor((x - s) / 2^k)
  function automatic longint filt(input longint s, input int d, input int k, input bit en, input bit init);
    longint x, diff, q, p;
    x = longint'(d) * 256;
    if (!init || !en || k == 0) return x;
    diff = x - s;
    p = longint'(1) << k;
    q = diff / p;
    if (diff < 0 && q * p != diff) q = q - 1;
    return s + q;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      foreach (m_s[i]) begin m_s[i] = 0; m_init[i] = 0; end
      p1_v = 0; p2_v = 0;
      e_vld = 0; e_upd = 0; e_dout = 0; e_ch = 0;
    end else begin
      e_vld = 0; e_upd = 0;
      if (p2_v) begin
        longint sn;
        int o_old, o_new;
        sn    = filt(m_s[p2_ch], p2_d, p2_k, p2_en, m_init[p2_ch]);
        o_old = out_of(m_s[p2_ch]);
        o_new = out_of(sn);
        e_vld = 1; e_dout = o_new; e_ch = p2_ch;
        e_upd = !m_init[p2_ch] || (o_new != o_old);
        if (!avg_clr) begin m_s[p2_ch] = sn; m_init[p2_ch] = 1; end
      end
      p2_v = p1_v && !avg_clr; p2_d = p1_d; p2_ch = p1_ch; p2_k = p1_k; p2_en = p1_en;
      if (avg_clr) foreach (m_init[i]) m_init[i] = 0;
      p1_v = din_vld; p1_d = int'(din); p1_ch = int'(din_ch); p1_k = int'(alpha_sel); p1_en = avg_en;
    end
    #1;
    chk("vld", dout_vld, e_vld);
    if (e_vld) begin
      chk("dout", dout, e_dout);
      chk("ch", dout_ch, e_ch);
      chk("upd", dout_update, e_upd);
    end else begin
      chk("dout_hold", dout, e_dout);
      chk("ch_hold", dout_ch, e_ch);
    end
    if (dout_vld) log_q.push_back('{cyc, int'(dout), int'(dout_ch), dout_update});
    if (oor_vld) oor_q.push_back('{cyc, int'(oor_dout), int'(oor_dout_ch), oor_upd});
  end

  task automatic drive(input bit v, input int d, input int ch, input int k, input bit en, input bit clr);
    din_vld = v; din = 16'(d); din_ch = 2'(ch); alpha_sel = 3'(k); avg_en = en; avg_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 1, 0);
  endtask

  task automatic ev_chk(input string nm, input int idx, input int d, input int ch, input bit upd);
    if (idx >= log_q.size()) begin
      vectors++; errors++;
      $display("FAIL %s: output missing, got %0d outputs want index %0d", nm, log_q.size(), idx);
    end else begin
      chk({nm, "_d"}, log_q[idx].d, d);
      chk({nm, "_ch"}, log_q[idx].ch, ch);
      chk({nm, "_upd"}, log_q[idx].upd, upd);
    end
  endtask

  initial begin
    int base, t, ob;
    rst = 1; din = 0; din_ch = 0; din_vld = 0; avg_clr = 0; avg_en = 1; alpha_sel = 0; oor_ch = 0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0); chk("rst_ch", dout_ch, 0);
    chk("rst_vld", dout_vld, 0); chk("rst_upd", dout_update, 0);
    rst = 0;

    base = log_q.size();
    drive(1, 1000, 0, 2, 1, 0); idle(2);
    drive(1, 2000, 0, 2, 1, 0); idle(2);
    drive(1, 2000, 0, 2, 1, 0); idle(4);
    chk("warm_n", log_q.size() - base, 3);
    ev_chk("warm0", base, 1000, 0, 1);
    ev_chk("warm1", base + 1, 1250, 0, 1);
    ev_chk("warm2", base + 2, WARM3, 0, 1);

    base = log_q.size();
    drive(1, 2000, 0, 2, 1, 0);
    drive(1, 3000, 0, 2, 1, 1);
    t = cyc;
    idle(4);
    chk("clr_n", log_q.size() - base, 1);
    ev_chk("clr0", base, 3000, 0, 1);
    if (log_q.size() > base) chk("clr_lat", log_q[base].cyc - t, 2);

    drive(0, 0, 0, 0, 1, 1); idle(2);
    base = log_q.size();
    drive(1, 1000, 0, 2, 1, 0);
    drive(1, 2000, 0, 2, 1, 0);
    drive(1, 2000, 0, 2, 1, 0);
    idle(4);
    chk("fwd_n", log_q.size() - base, 3);
    ev_chk("fwd0", base, 1000, 0, 1);
    ev_chk("fwd1", base + 1, 1250, 0, 1);
    ev_chk("fwd2", base + 2, WARM3, 0, 1);
    if (log_q.size() >= base + 3) chk("fwd_span", log_q[base + 2].cyc - log_q[base].cyc, 2);

    drive(0, 0, 0, 0, 1, 1); idle(2);
    base = log_q.size();
    drive(1, 1000, 0, 1, 1, 0);
    drive(1, 40000, 1, 1, 1, 0);
    drive(1, 2000, 0, 1, 1, 0);
    drive(1, 0, 1, 1, 1, 0);
    idle(4);
    ev_chk("il0", base, 1000, 0, 1);
    ev_chk("il1", base + 1, 40000, 1, 1);
    ev_chk("il2", base + 2, 1500, 0, 1);
    ev_chk("il3", base + 3, 20000, 1, 1);

    base = log_q.size();
    repeat (10) drive(1, 500, 2, 3, 1, 0);
    idle(4);
    chk("steady_n", log_q.size() - base, 10);
    for (int i = 0; i < 10; i++) ev_chk($sformatf("steady%0d", i), base + i, 500, 2, i == 0);

    base = log_q.size();
    drive(1, 777, 1, 2, 0, 0);
    drive(1, 65535, 3, 5, 0, 0);
    drive(1, 0, 1, 0, 1, 0);
    idle(4);
    ev_chk("pass0", base, 777, 1, 1);
    ev_chk("pass1", base + 1, 65535, 3, 1);
    ev_chk("pass2", base + 2, 0, 1, 1);

    ob = oor_q.size();
    oor_ch = 5; drive(1, 111, 0, 2, 1, 0);
    oor_ch = 4; drive(1, 123, 0, 2, 1, 0);
    oor_ch = 7; drive(1, 222, 0, 2, 1, 0);
    oor_ch = 0; idle(4);
    chk("oor_n", oor_q.size() - ob, 1);
    if (oor_q.size() > ob) begin
      chk("oor_d", oor_q[ob].d, 123);
      chk("oor_ch", oor_q[ob].ch, 4);
      chk("oor_upd", oor_q[ob].upd, 1);
    end

    for (int i = 0; i < 1500; i++) begin
      int pick, d;
      pick = $urandom_range(0, 9);
      d = (pick == 0) ? 0 : (pick == 1) ? 65535 : $urandom_range(0, 65535);
      rst = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom_range(0, 7) != 0, $urandom_range(0, 60) == 0);
      rst = 0;
    end
    idle(4);

    drive(1, 4000, 0, 2, 1, 0);
    drive(1, 5000, 1, 2, 1, 0);
    rst = 1;
    drive(1, 9, 0, 2, 1, 0);
    rst = 0;
    chk("mid_rst_dout", dout, 0); chk("mid_rst_ch", dout_ch, 0);
    chk("mid_rst_vld", dout_vld, 0); chk("mid_rst_upd", dout_update, 0);
    base = log_q.size();
    drive(1, 7, 0, 2, 1, 0);
    idle(3);
    chk("post_rst_n", log_q.size() - base, 1);
    ev_chk("post_rst", base, 7, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
